// File: rtl/sccb_init_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_init_pkg
//  Purpose  : Shared types and constants for the OV7670 SCCB init sequencer:
//             FSM state encoding, register-table entry format, COM7 soft-reset
//             entry and the default table length.
//  Revision : 1.0 - initial release
// ============================================================================
package sccb_init_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_POWER_WAIT = 3'd1,
        ST_SEND       = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_GAP        = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // One table entry: {register address, register value}
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] value;
    } entry_t;

    localparam logic [15:0] c_COM7_RESET      = 16'h1280;
    localparam logic [15:0] c_ROM_INVALID     = 16'hFFFF;
    localparam logic [7:0]  c_REG_NUM_DEFAULT = 8'd72;

endpackage
`default_nettype wire

// File: rtl/sccb_init_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_init_ctrl_if
//  Purpose  : Control/status and sender-side bus of the SCCB init sequencer.
//  Signals  : start      - (re)start pulse from top-level control
//             send_done  - done pulse from the SCCB sender
//             send_en    - one-cycle write request to the sender
//             addr/value - register address/data, valid with send_en
//             busy       - sequence in progress
//             init_done  - whole table written
//             cfg_index  - index of the entry being sent
//             err        - sticky retry-exhaustion flag
//  Modports : master (sequencer side), slave (controller/sender side)
//  Revision : 1.0 - initial release
// ============================================================================
interface sccb_init_ctrl_if;
    import sccb_init_pkg::*;

    logic       start;
    logic       send_done;
    logic       send_en;
    logic [7:0] addr;
    logic [7:0] value;
    logic       busy;
    logic       init_done;
    logic [7:0] cfg_index;
    logic       err;

    modport master (
        input  start, send_done,
        output send_en, addr, value, busy, init_done, cfg_index, err
    );

    modport slave (
        output start, send_done,
        input  send_en, addr, value, busy, init_done, cfg_index, err
    );
endinterface
`default_nettype wire

// File: rtl/sccb_init_ctrl_rom.sv
`default_nettype none
// ============================================================================
//  Module   : ov7670_reg_rom
//  Purpose  : Combinational OV7670 configuration table (QVGA, RGB565).
//             Entry 0 is the COM7 soft reset; indices >= REG_NUM read 16'hFFFF.
//  Ports    : i_index[7:0] - table index
//             o_data[15:0] - {addr, value}
//  Revision : 1.0 - initial release
// ============================================================================
module ov7670_reg_rom
    import sccb_init_pkg::*;
#(
    parameter logic [7:0] REG_NUM = c_REG_NUM_DEFAULT
) (
    input  wire logic [7:0]  i_index,
    output logic      [15:0] o_data
);
    logic [15:0] w_tab;

    always_comb begin
        w_tab = c_ROM_INVALID;
        case (i_index)
            8'd0:  w_tab = c_COM7_RESET; 8'd1:  w_tab = 16'h1204; 8'd2:  w_tab = 16'h1100;
            8'd3:  w_tab = 16'h0C04;     8'd4:  w_tab = 16'h3E19; 8'd5:  w_tab = 16'h4010;
            8'd6:  w_tab = 16'h8C00;     8'd7:  w_tab = 16'h1716; 8'd8:  w_tab = 16'h1804;
            8'd9:  w_tab = 16'h32A4;     8'd10: w_tab = 16'h1902; 8'd11: w_tab = 16'h1A7A;
            8'd12: w_tab = 16'h030A;     8'd13: w_tab = 16'h703A; 8'd14: w_tab = 16'h7135;
            8'd15: w_tab = 16'h7211;     8'd16: w_tab = 16'h73F1; 8'd17: w_tab = 16'hA202;
            8'd18: w_tab = 16'h1500;     8'd19: w_tab = 16'h7A20; 8'd20: w_tab = 16'h7B10;
            8'd21: w_tab = 16'h7C1E;     8'd22: w_tab = 16'h7D35; 8'd23: w_tab = 16'h7E5A;
            8'd24: w_tab = 16'h7F69;     8'd25: w_tab = 16'h8076; 8'd26: w_tab = 16'h8180;
            8'd27: w_tab = 16'h8288;     8'd28: w_tab = 16'h838F; 8'd29: w_tab = 16'h8496;
            8'd30: w_tab = 16'h85A3;     8'd31: w_tab = 16'h86AF; 8'd32: w_tab = 16'h87C4;
            8'd33: w_tab = 16'h88D7;     8'd34: w_tab = 16'h89E8; 8'd35: w_tab = 16'h13E0;
            8'd36: w_tab = 16'h0000;     8'd37: w_tab = 16'h1000; 8'd38: w_tab = 16'h0D40;
            8'd39: w_tab = 16'h1418;     8'd40: w_tab = 16'hA505; 8'd41: w_tab = 16'hAB07;
            8'd42: w_tab = 16'h2495;     8'd43: w_tab = 16'h2533; 8'd44: w_tab = 16'h26E3;
            8'd45: w_tab = 16'h9F78;     8'd46: w_tab = 16'hA068; 8'd47: w_tab = 16'hA103;
            8'd48: w_tab = 16'hA6D8;     8'd49: w_tab = 16'hA7D8; 8'd50: w_tab = 16'hA8F0;
            8'd51: w_tab = 16'hA990;     8'd52: w_tab = 16'hAA94; 8'd53: w_tab = 16'h13E5;
            8'd54: w_tab = 16'h4F80;     8'd55: w_tab = 16'h5080; 8'd56: w_tab = 16'h5100;
            8'd57: w_tab = 16'h5222;     8'd58: w_tab = 16'h535E; 8'd59: w_tab = 16'h5480;
            8'd60: w_tab = 16'h589E;     8'd61: w_tab = 16'h3DC0; 8'd62: w_tab = 16'h4108;
            8'd63: w_tab = 16'h3F00;     8'd64: w_tab = 16'h7530; 8'd65: w_tab = 16'h7602;
            8'd66: w_tab = 16'h4C00;     8'd67: w_tab = 16'h7700; 8'd68: w_tab = 16'h4B09;
            8'd69: w_tab = 16'hC960;     8'd70: w_tab = 16'h5540; 8'd71: w_tab = 16'h5640;
            default: w_tab = c_ROM_INVALID;
        endcase
    end

    // A shortened table (REG_NUM < 72) hides the tail entries
    assign o_data = (i_index < REG_NUM) ? w_tab : c_ROM_INVALID;
endmodule
`default_nettype wire

// File: rtl/sccb_init_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_init_ctrl
//  Purpose  : OV7670 power-up configuration sequencer. Waits a power-up delay,
//             then streams the register table into the SCCB sender, one
//             send_en per entry, with an inter-write gap (longer settle gap
//             after the COM7 soft reset). Flags init_done when finished.
//  Ports    : clk, rst (async, active-high)
//             bus - sccb_init_ctrl_if.master (start/send_done in; send_en,
//                   addr, value, busy, init_done, cfg_index, err out)
//  Options  : SCCB_INIT_TIMEOUT_EN - WAIT_DONE timeout with per-entry retry
//             and sticky err; without it err is tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sccb_init_ctrl
    import sccb_init_pkg::*;
#(
    parameter logic [7:0]  REG_NUM             = c_REG_NUM_DEFAULT,
    parameter logic [23:0] POWERUP_CYCLES      = 24'd500000,
    parameter logic [15:0] GAP_CYCLES          = 16'd1000,
    parameter logic [23:0] RESET_SETTLE_CYCLES = 24'd25000,
    parameter logic        AUTO_START          = 1'b1
`ifdef SCCB_INIT_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CYCLES      = 16'd20000,
    parameter logic [2:0]  MAX_RETRY           = 3'd3
`endif
) (
    input wire logic         clk,
    input wire logic         rst,
    sccb_init_ctrl_if.master bus
);
    state_t      r_state,     w_state_nxt;
    logic [23:0] r_cnt,       w_cnt_nxt;
    logic [7:0]  r_idx,       w_idx_nxt;
    logic        r_init_done, w_init_done_nxt;
    logic        r_send_en;
    logic        r_busy;
    entry_t      r_entry;
    logic        w_advance;
    logic [15:0] w_rom_data;
`ifdef SCCB_INIT_TIMEOUT_EN
    logic [15:0] r_to_cnt,    w_to_cnt_nxt;
    logic [2:0]  r_retry,     w_retry_nxt;
    logic        r_err,       w_err_nxt;
`endif

    // ROM is addressed with the next index so addr/value register together
    // with send_en on entry into SEND.
    ov7670_reg_rom #(.REG_NUM(REG_NUM)) u_rom (
        .i_index (w_idx_nxt),
        .o_data  (w_rom_data)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_init_done_nxt = r_init_done;
        w_advance       = 1'b0;
`ifdef SCCB_INIT_TIMEOUT_EN
        w_to_cnt_nxt    = r_to_cnt;
        w_retry_nxt     = r_retry;
        w_err_nxt       = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (AUTO_START || bus.start) begin
                    w_state_nxt = ST_POWER_WAIT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            ST_POWER_WAIT: begin
                if (r_cnt == POWERUP_CYCLES - 24'd1) begin
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 24'd1;
                end
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT_DONE;
`ifdef SCCB_INIT_TIMEOUT_EN
                w_to_cnt_nxt = '0;
`endif
            end
            ST_WAIT_DONE: begin
                if (bus.send_done) begin
                    w_advance = 1'b1;
                end
`ifdef SCCB_INIT_TIMEOUT_EN
                else if (r_to_cnt == TIMEOUT_CYCLES - 16'd1) begin
                    // Out of retries: flag it and move on so init still completes
                    if (r_retry == MAX_RETRY) begin
                        w_err_nxt = 1'b1;
                        w_advance = 1'b1;
                    end else begin
                        w_retry_nxt = r_retry + 3'd1;
                        w_state_nxt = ST_SEND;
                    end
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 16'd1;
                end
`endif
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt     = ST_POWER_WAIT;
                    w_cnt_nxt       = '0;
                    w_idx_nxt       = '0;
                    w_init_done_nxt = 1'b0;
`ifdef SCCB_INIT_TIMEOUT_EN
                    w_err_nxt       = 1'b0;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Entry finished (done received or retries exhausted)
        if (w_advance) begin
`ifdef SCCB_INIT_TIMEOUT_EN
            w_retry_nxt = '0;
`endif
            if (r_idx == REG_NUM - 8'd1) begin
                w_state_nxt     = ST_DONE;
                w_init_done_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_GAP;
                w_idx_nxt   = r_idx + 8'd1;
                // The soft reset needs a longer settle time than a normal write
                w_cnt_nxt   = (r_idx == 8'd0) ? RESET_SETTLE_CYCLES : {8'h00, GAP_CYCLES};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_send_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_entry     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_init_done <= w_init_done_nxt;
            r_send_en   <= (w_state_nxt == ST_SEND);
            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            if (w_state_nxt == ST_SEND) begin
                r_entry <= w_rom_data;
            end
        end
    end

`ifdef SCCB_INIT_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_retry  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
            r_retry  <= w_retry_nxt;
            r_err    <= w_err_nxt;
        end
    end
    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.send_en   = r_send_en;
    assign bus.addr      = r_entry.addr;
    assign bus.value     = r_entry.value;
    assign bus.busy      = r_busy;
    assign bus.init_done = r_init_done;
    assign bus.cfg_index = r_idx;
endmodule
`default_nettype wire
